// File: rtl/lsu.sv
// Load/store unit: aligned LB/LH/LW/LBU/LHU/SB/SH/SW to a req/ack bus; plain results pass through with 1-cycle latency.
// A memory op takes IDLE->BUSY->DONE (>=3 cycles) and holds stall_o until ack; misaligned ops just pulse misalign_o.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic        mem_r_ena_i,
  input  logic        mem_w_ena_i,
  input  logic [31:0] mem_r_addr_i,
  input  logic [31:0] mem_w_addr_i,
  input  logic        reg_w_ena_i,
  input  logic [4:0]  reg_w_addr_i,
  input  logic [31:0] reg_w_data_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic        reg_w_ena_o,
  output logic [4:0]  reg_w_addr_o,
  output logic [31:0] reg_w_data_o,
  output logic        stall_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  state_t state_q, state_d;

  logic        dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic        reg_w_ena_q, reg_w_ena_d;
  logic [4:0]  reg_w_addr_q, reg_w_addr_d;
  logic [31:0] reg_w_data_q, reg_w_data_d;
  logic        misalign_q, misalign_d;
  logic        op_store_q, op_store_d, op_ena_q, op_ena_d;
  logic [2:0]  op_f3_q, op_f3_d;
  logic [1:0]  op_lo_q, op_lo_d;
  logic [4:0]  op_rd_q, op_rd_d;

  logic [2:0]  funct3;
  logic        is_mem, is_store, is_half, is_word, misalign, go;
  logic [31:0] addr, wdata, load_val;
  logic [3:0]  be;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic        unused_inst;

  assign funct3      = inst_i[14:12];
  assign unused_inst = ^{inst_i[31:15], inst_i[11:0]};
  assign is_store    = mem_w_ena_i;
  assign is_mem      = mem_r_ena_i | mem_w_ena_i;
  assign addr        = is_store ? mem_w_addr_i : mem_r_addr_i;
  assign is_half     = (funct3 == 3'd1) || (!is_store && funct3 == 3'd5);
  assign is_word     = (funct3 == 3'd2);
  assign misalign    = is_mem && ((is_half && addr[0]) || (is_word && addr[1:0] != 2'b00));
  assign go          = (state_q == IDLE) && is_mem && !misalign;

  always_comb begin
    be    = 4'b0000;
    wdata = reg_w_data_i;
    case (funct3[1:0])
      2'd0: begin
        be    = 4'b0001 << addr[1:0];
        wdata = {4{reg_w_data_i[7:0]}};
      end
      2'd1: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{reg_w_data_i[15:0]}};
      end
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    // Store funct3 values above SW are not real stores: touch no lanes.
    if (is_store && funct3[2]) be = 4'b0000;
  end

  always_comb begin
    rbyte    = dmem_rdata_i[{op_lo_q, 3'b000} +: 8];
    rhalf    = op_lo_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    load_val = 32'h0;
    case (op_f3_q)
      3'd0:    load_val = {{24{rbyte[7]}}, rbyte};
      3'd1:    load_val = {{16{rhalf[15]}}, rhalf};
      3'd2:    load_val = dmem_rdata_i;
      3'd4:    load_val = {24'h0, rbyte};
      3'd5:    load_val = {16'h0, rhalf};
      default: load_val = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'h0;
      dmem_wdata_q <= 32'h0;
      dmem_be_q    <= 4'h0;
      reg_w_ena_q  <= 1'b0;
      reg_w_addr_q <= 5'h0;
      reg_w_data_q <= 32'h0;
      misalign_q   <= 1'b0;
      op_store_q   <= 1'b0;
      op_ena_q     <= 1'b0;
      op_f3_q      <= 3'h0;
      op_lo_q      <= 2'h0;
      op_rd_q      <= 5'h0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_be_q    <= dmem_be_d;
      reg_w_ena_q  <= reg_w_ena_d;
      reg_w_addr_q <= reg_w_addr_d;
      reg_w_data_q <= reg_w_data_d;
      misalign_q   <= misalign_d;
      op_store_q   <= op_store_d;
      op_ena_q     <= op_ena_d;
      op_f3_q      <= op_f3_d;
      op_lo_q      <= op_lo_d;
      op_rd_q      <= op_rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = BUSY;
      BUSY:    if (dmem_ack_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_o      = !rst && ((state_q == BUSY) || go);
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_be_d    = dmem_be_q;
    reg_w_ena_d  = 1'b0;
    reg_w_addr_d = reg_w_addr_q;
    reg_w_data_d = reg_w_data_q;
    misalign_d   = 1'b0;
    op_store_d   = op_store_q;
    op_ena_d     = op_ena_q;
    op_f3_d      = op_f3_q;
    op_lo_d      = op_lo_q;
    op_rd_d      = op_rd_q;
    case (state_q)
      IDLE: begin
        if (!is_mem) begin
          reg_w_ena_d  = reg_w_ena_i;
          reg_w_addr_d = reg_w_addr_i;
          reg_w_data_d = reg_w_data_i;
        end else if (misalign) begin
          misalign_d = 1'b1;
        end else begin
          dmem_req_d   = 1'b1;
          dmem_we_d    = is_store;
          dmem_addr_d  = {addr[31:2], 2'b00};
          dmem_wdata_d = wdata;
          dmem_be_d    = be;
          op_store_d   = is_store;
          op_ena_d     = reg_w_ena_i;
          op_f3_d      = funct3;
          op_lo_d      = addr[1:0];
          op_rd_d      = reg_w_addr_i;
        end
      end
      BUSY: begin
        if (dmem_ack_i) begin
          dmem_req_d   = 1'b0;
          reg_w_ena_d  = op_ena_q & ~op_store_q;
          reg_w_addr_d = op_rd_q;
          reg_w_data_d = op_store_q ? 32'h0 : load_val;
        end
      end
      default: ;
    endcase
  end

  assign dmem_req_o   = dmem_req_q;
  assign dmem_we_o    = dmem_we_q;
  assign dmem_addr_o  = dmem_addr_q;
  assign dmem_wdata_o = dmem_wdata_q;
  assign dmem_be_o    = dmem_be_q;
  assign reg_w_ena_o  = reg_w_ena_q;
  assign reg_w_addr_o = reg_w_addr_q;
  assign reg_w_data_o = reg_w_data_q;
  assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed vector table, reset corner sequences, then random ops against a lane-level reference model.
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic        mem_r_ena_i, mem_w_ena_i;
  logic [31:0] mem_r_addr_i, mem_w_addr_i;
  logic        reg_w_ena_i;
  logic [4:0]  reg_w_addr_i;
  logic [31:0] reg_w_data_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_rdata_i;
  logic        dmem_ack_i;
  logic        reg_w_ena_o;
  logic [4:0]  reg_w_addr_o;
  logic [31:0] reg_w_data_o;
  logic        stall_o, misalign_o;

  lsu dut (
    .clk(clk), .rst(rst), .inst_i(inst_i),
    .mem_r_ena_i(mem_r_ena_i), .mem_w_ena_i(mem_w_ena_i),
    .mem_r_addr_i(mem_r_addr_i), .mem_w_addr_i(mem_w_addr_i),
    .reg_w_ena_i(reg_w_ena_i), .reg_w_addr_i(reg_w_addr_i), .reg_w_data_i(reg_w_data_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
    .reg_w_ena_o(reg_w_ena_o), .reg_w_addr_o(reg_w_addr_o), .reg_w_data_o(reg_w_data_o),
    .stall_o(stall_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ld;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
    bit          wena;
    logic [31:0] rdata;
    int          ack_wait;
    bit          exp_req;
    bit          exp_mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    bit          exp_wb_ena;
    logic [31:0] exp_wb_data;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: access size in bytes, lane range [off, off+size), sign from funct3 bit 2.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int nb, off;
    bit mem, mis;
    logic [31:0] m, val;
    r = v;
    mem = v.ld || v.st;
    case (v.f3)
      3'd0, 3'd4: nb = 1;
      3'd1, 3'd5: nb = 2;
      3'd2:       nb = 4;
      default:    nb = 0;
    endcase
    off = int'(v.addr % 4);
    mis = mem && nb > 1 && (v.addr % nb) != 0;
    r.exp_mis = mis;
    r.exp_req = mem && !mis;
    r.exp_addr = v.addr - off;
    r.exp_be = 4'h0;
    r.exp_wdata = 32'h0;
    if (v.st && nb > 0)
      for (int k = 0; k < 4; k++) begin
        r.exp_be[k] = (k >= off) && (k < off + nb);
        r.exp_wdata[8*k +: 8] = v.data[8*(k % nb) +: 8];
      end
    val = 32'h0;
    if (nb > 0) begin
      m = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
      val = (v.rdata >> (8 * off)) & m;
      if (v.f3 < 3'd4 && val[8*nb-1]) val = val | ~m;
    end
    if (!mem) begin
      r.exp_wb_ena = v.wena;
      r.exp_wb_data = v.data;
    end else if (mis || v.st) begin
      r.exp_wb_ena = 1'b0;
      r.exp_wb_data = 32'h0;
    end else begin
      r.exp_wb_ena = v.wena;
      r.exp_wb_data = val;
    end
    return r;
  endfunction

  task automatic idle_inputs();
    inst_i = 32'h0000_0013;
    mem_r_ena_i = 1'b0;
    mem_w_ena_i = 1'b0;
    mem_r_addr_i = 32'h0;
    mem_w_addr_i = 32'h0;
    reg_w_ena_i = 1'b0;
    reg_w_addr_i = 5'h0;
    reg_w_data_i = 32'h0;
    dmem_ack_i = 1'b0;
  endtask

  // Entered and left at a negedge with the DUT in IDLE and inputs idle.
  task automatic apply(input vec_t v, input string tag);
    int stall_cnt;
    stall_cnt = 0;
    inst_i = $urandom;
    inst_i[14:12] = v.f3;
    mem_r_ena_i = v.ld;
    mem_w_ena_i = v.st;
    mem_w_addr_i = v.st ? v.addr : ~v.addr;
    mem_r_addr_i = v.st ? (v.addr ^ 32'h44) : v.addr;
    reg_w_ena_i = v.wena;
    reg_w_addr_i = v.rd;
    reg_w_data_i = v.data;
    dmem_rdata_i = $urandom;
    #1;
    chk({tag, " stall_issue"}, stall_o, v.exp_req);
    if (stall_o) stall_cnt++;
    @(negedge clk);
    if (!v.exp_req) begin
      idle_inputs();
      #1;
      chk({tag, " misalign"}, misalign_o, v.exp_mis);
      chk({tag, " req_none"}, dmem_req_o, 0);
      chk({tag, " stall_none"}, stall_o, 0);
      chk({tag, " wb_ena"}, reg_w_ena_o, v.exp_wb_ena);
      if (v.exp_wb_ena) begin
        chk({tag, " wb_addr"}, reg_w_addr_o, v.rd);
        chk({tag, " wb_data"}, reg_w_data_o, v.exp_wb_data);
      end
      @(negedge clk);
      #1;
      chk({tag, " misalign_pulse_end"}, misalign_o, 0);
      chk({tag, " wb_ena_after"}, reg_w_ena_o, 0);
    end else begin
      for (int w = 1; w <= v.ack_wait; w++) begin
        dmem_ack_i = (w == v.ack_wait);
        dmem_rdata_i = (w == v.ack_wait) ? v.rdata : $urandom;
        #1;
        chk({tag, " busy_req"}, dmem_req_o, 1);
        chk({tag, " busy_stall"}, stall_o, 1);
        chk({tag, " busy_we"}, dmem_we_o, v.st);
        chk({tag, " busy_addr"}, dmem_addr_o, v.exp_addr);
        chk({tag, " busy_wb_ena"}, reg_w_ena_o, 0);
        if (v.st) begin
          chk({tag, " busy_be"}, dmem_be_o, v.exp_be);
          chk({tag, " busy_wdata"}, dmem_wdata_o, v.exp_wdata);
        end
        if (stall_o) stall_cnt++;
        @(negedge clk);
      end
      dmem_ack_i = 1'b0;
      #1;
      chk({tag, " done_stall"}, stall_o, 0);
      chk({tag, " done_req"}, dmem_req_o, 0);
      chk({tag, " done_wb_ena"}, reg_w_ena_o, v.exp_wb_ena);
      if (v.exp_wb_ena) begin
        chk({tag, " done_wb_addr"}, reg_w_addr_o, v.rd);
        chk({tag, " done_wb_data"}, reg_w_data_o, v.exp_wb_data);
      end
      chk({tag, " stall_cycles"}, stall_cnt, 1 + v.ack_wait);
      // Inputs and ack presented during DONE must be ignored.
      mem_r_ena_i = 1'b1;
      mem_r_addr_i = 32'h100;
      inst_i[14:12] = 3'd2;
      reg_w_ena_i = 1'b1;
      dmem_ack_i = 1'b1;
      @(negedge clk);
      #1;
      chk({tag, " after_done_req"}, dmem_req_o, 0);
      chk({tag, " after_done_wb_ena"}, reg_w_ena_o, 0);
      idle_inputs();
      #1;
      chk({tag, " after_done_stall"}, stall_o, 0);
      @(negedge clk);
    end
  endtask

  vec_t tbl[14];
  vec_t rv;
  int kind;

  initial begin
    tbl[0]  = '{0, 0, 3'd0, 32'h0,    32'h5,        5'd3,  1, 32'h0,         1, 0, 0, 32'h0,    4'h0, 32'h0,         1, 32'h5};
    tbl[1]  = '{1, 0, 3'd0, 32'h1003, 32'h0,        5'd7,  1, 32'h80FF_FF00, 2, 1, 0, 32'h1000, 4'h0, 32'h0,         1, 32'hFFFF_FF80};
    tbl[2]  = '{1, 0, 3'd4, 32'h1003, 32'h0,        5'd7,  1, 32'h80FF_FF00, 2, 1, 0, 32'h1000, 4'h0, 32'h0,         1, 32'h0000_0080};
    tbl[3]  = '{0, 1, 3'd1, 32'h2002, 32'h1234_ABCD, 5'd9, 1, 32'h0,         1, 1, 0, 32'h2000, 4'hC, 32'hABCD_ABCD, 0, 32'h0};
    tbl[4]  = '{1, 0, 3'd2, 32'h3001, 32'h0,        5'd4,  1, 32'h0,         1, 0, 1, 32'h0,    4'h0, 32'h0,         0, 32'h0};
    tbl[5]  = '{1, 1, 3'd2, 32'h40,   32'hDEAD_BEEF, 5'd5, 1, 32'h1111_1111, 1, 1, 0, 32'h40,   4'hF, 32'hDEAD_BEEF, 0, 32'h0};
    tbl[6]  = '{1, 0, 3'd1, 32'h2,    32'h0,        5'd6,  1, 32'h8001_7FFF, 3, 1, 0, 32'h0,    4'h0, 32'h0,         1, 32'hFFFF_8001};
    tbl[7]  = '{1, 0, 3'd5, 32'h2,    32'h0,        5'd6,  1, 32'h8001_7FFF, 1, 1, 0, 32'h0,    4'h0, 32'h0,         1, 32'h0000_8001};
    tbl[8]  = '{0, 1, 3'd0, 32'h101,  32'h1234_56A5, 5'd2, 1, 32'h0,         1, 1, 0, 32'h100,  4'h2, 32'hA5A5_A5A5, 0, 32'h0};
    tbl[9]  = '{1, 0, 3'd2, 32'h10,   32'h0,        5'd31, 1, 32'h1234_5678, 1, 1, 0, 32'h10,   4'h0, 32'h0,         1, 32'h1234_5678};
    tbl[10] = '{0, 1, 3'd1, 32'h3,    32'h0,        5'd1,  1, 32'h0,         1, 0, 1, 32'h0,    4'h0, 32'h0,         0, 32'h0};
    tbl[11] = '{1, 0, 3'd3, 32'h20,   32'h0,        5'd8,  1, 32'hFFFF_FFFF, 1, 1, 0, 32'h20,   4'h0, 32'h0,         1, 32'h0};
    tbl[12] = '{0, 1, 3'd0, 32'h3,    32'h0000_007E, 5'd1, 0, 32'h0,         2, 1, 0, 32'h0,    4'h8, 32'h7E7E_7E7E, 0, 32'h0};
    tbl[13] = '{1, 0, 3'd0, 32'h1,    32'h0,        5'd12, 1, 32'h0000_7F00, 1, 1, 0, 32'h0,    4'h0, 32'h0,         1, 32'h0000_007F};

    // Reset with a memory op already on the inputs: no stall while rst is high.
    idle_inputs();
    dmem_rdata_i = 32'h0;
    rst = 1'b1;
    mem_r_ena_i = 1'b1;
    mem_r_addr_i = 32'h100;
    inst_i[14:12] = 3'd2;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset stall", stall_o, 0);
    chk("reset req", dmem_req_o, 0);
    chk("reset we", dmem_we_o, 0);
    chk("reset addr", dmem_addr_o, 0);
    chk("reset wdata", dmem_wdata_o, 0);
    chk("reset be", dmem_be_o, 0);
    chk("reset wb_ena", reg_w_ena_o, 0);
    chk("reset wb_addr", reg_w_addr_o, 0);
    chk("reset wb_data", reg_w_data_o, 0);
    chk("reset misalign", misalign_o, 0);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a store transfer, then a late ack.
    inst_i = 32'h0;
    inst_i[14:12] = 3'd2;
    mem_w_ena_i = 1'b1;
    mem_w_addr_i = 32'h80;
    reg_w_data_i = 32'hCAFE_F00D;
    #1;
    chk("rstbusy stall_issue", stall_o, 1);
    @(negedge clk);
    #1;
    chk("rstbusy req", dmem_req_o, 1);
    chk("rstbusy be", dmem_be_o, 4'hF);
    rst = 1'b1;
    idle_inputs();
    #1;
    chk("rstbusy stall_in_rst", stall_o, 0);
    @(negedge clk);
    #1;
    chk("rstbusy req_after_edge", dmem_req_o, 0);
    chk("rstbusy wb_after_edge", reg_w_ena_o, 0);
    rst = 1'b0;
    dmem_ack_i = 1'b1;
    dmem_rdata_i = 32'h5555_5555;
    @(negedge clk);
    #1;
    chk("rstbusy late_ack_req", dmem_req_o, 0);
    chk("rstbusy late_ack_wb", reg_w_ena_o, 0);
    chk("rstbusy late_ack_stall", stall_o, 0);
    dmem_ack_i = 1'b0;
    @(negedge clk);
    apply(tbl[9], "post_reset_lw");

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 3);
      rv.ld = (kind == 1) || (kind == 3);
      rv.st = (kind >= 2);
      rv.f3 = rv.st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
      rv.addr = $urandom;
      rv.data = $urandom;
      rv.rd = 5'($urandom);
      rv.wena = 1'($urandom_range(0, 1));
      rv.rdata = $urandom;
      rv.ack_wait = $urandom_range(1, 3);
      apply(model(rv), $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL have no parameters: data/address fixed at 32 bits, register address at 5 bits.
REQ-002 The block SHALL use one clock with a synchronous, active-high reset, on the ports below.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 inst_i  input  32  instruction from execute; funct3 = inst_i[14:12].
REQ-006 mem_r_ena_i / mem_w_ena_i  input  1 each  load / store request from execute.
REQ-007 mem_r_addr_i / mem_w_addr_i  input  32 each  load / store byte address.
REQ-008 reg_w_ena_i  input  1  register write enable.
REQ-009 reg_w_addr_i  input  5  destination register.
REQ-010 reg_w_data_i  input  32  ALU result; carries rs2 store data for stores.
REQ-011 dmem_req_o  output  1  bus request.
REQ-012 dmem_we_o  output  1  1 = write.
REQ-013 dmem_addr_o  output  32  word-aligned address, [1:0] = 0.
REQ-014 dmem_wdata_o  output  32  lane-replicated store data.
REQ-015 dmem_be_o  output  4  byte enables.
REQ-016 dmem_rdata_i  input  32  read word.
REQ-017 dmem_ack_i  input  1  transfer done.
REQ-018 reg_w_ena_o / reg_w_addr_o / reg_w_data_o  output  1/5/32  registered writeback to wb.
REQ-019 stall_o  output  1  hold execute and earlier stages.
REQ-020 misalign_o  output  1  one-cycle misaligned-access pulse.

Function
REQ-021 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-022 In IDLE with no memory op, the block SHALL register the reg_w_* inputs to the reg_w_* outputs (1-cycle latency, stall_o = 0).
REQ-023 In IDLE with an aligned memory op, the block SHALL assert stall_o combinationally, latch the op, and go to BUSY.
REQ-024 A memory op with both enables high SHALL be treated as a store; the load request is ignored.
REQ-025 In BUSY, the block SHALL hold dmem_req_o = 1, keep all dmem_* outputs stable, and keep stall_o = 1 until dmem_ack_i is sampled high.
REQ-026 When dmem_ack_i is sampled high, the block SHALL drop dmem_req_o on that edge and go to DONE.
REQ-027 dmem_ack_i SHALL be ignored outside BUSY.
REQ-028 In DONE, stall_o SHALL be 0, the inputs SHALL be ignored (the completed op is still presented), and the next state SHALL be IDLE.
REQ-029 Minimum occupancy of a memory op SHALL be 3 cycles (IDLE, BUSY with ack in the same cycle, DONE).
REQ-030 Loads SHALL decode funct3 as 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU, extracting the lane selected by addr[1:0] and sign- or zero-extending it.
REQ-031 The load result SHALL appear on reg_w_data_o in the DONE cycle with reg_w_ena_o = reg_w_ena_i as latched.
REQ-032 Loads with any other funct3 SHALL return 0.
REQ-033 Stores SHALL decode funct3 as 0 SB, 1 SH, 2 SW.
REQ-034 SB SHALL set be = 1 << addr[1:0], with data byte replicated 4x.
REQ-035 SH SHALL set be = addr[1] ? 1100 : 0011, with data halfword replicated 2x.
REQ-036 SW SHALL set be = 1111.
REQ-037 A store SHALL drive reg_w_ena_o = 0.
REQ-038 Halfword accesses with addr[0] = 1, and word accesses with addr[1:0] != 0, SHALL issue no bus request and raise no stall.
REQ-039 Such a misaligned access SHALL pulse misalign_o for one cycle and drive reg_w_ena_o = 0 in the next cycle.
REQ-040 Outside DONE and non-memory pass-through, reg_w_ena_o SHALL be 0.

Reset
REQ-041 On rst, the block SHALL enter IDLE and clear every output to 0: dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o, reg_w_*, misalign_o. stall_o SHALL be 0 while rst is high.
REQ-042 A reset during BUSY SHALL abandon the transfer, with dmem_req_o low from the next edge; a late dmem_ack_i SHALL be ignored.

Verification
REQ-043 ADDI result 0x5 to x3, no mem op -> next cycle reg_w_ena_o = 1, reg_w_addr_o = 3, reg_w_data_o = 0x5, stall_o never high.
REQ-044 LB at address 0x1003, ack after 2 BUSY cycles with rdata 0x80FF_FF00 -> dmem_addr_o = 0x1000, stall_o high for 3 cycles, DONE reg_w_data_o = 0xFFFF_FF80; the same access as LBU gives 0x0000_0080.
REQ-045 SH at address 0x2002 with data 0x1234_ABCD -> dmem_be_o = 1100, dmem_wdata_o = 0xABCD_ABCD, dmem_we_o = 1, reg_w_ena_o = 0 in DONE.
REQ-046 LW at address 0x3001 -> no dmem_req_o, stall_o = 0, misalign_o pulses once, reg_w_ena_o = 0.
REQ-047 SW issued, rst asserted mid-BUSY, then ack -> dmem_req_o = 0 after the reset edge, state IDLE, no writeback.
REQ-048 Both enables high, funct3 = 2, address 0x40 -> store with be = 1111; no load writeback.
